pixel_unpack_ctrl: RTL and testbench
====================================

// Module: pixel_unpack_ctrl
// PURPOSE
//  Sequencer for the video pixel path: accepts 32-bit packed words from the line FIFO and steps a field select
//  through each word to emit one palette index per pixel at 1/2/4/8 bpp. Field 0 is the least-significant field.
//  Uses a demux_32_2 instance for the 2bpp case. Sits between the line FIFO read side and the palette lookup.
// PARAMETERS
//  none.
// PORTS
//  clk         in   1   pixel clock
//  reset       in   1   synchronous, active-high reset
//  mode        in   2   bpp: 0=1bpp (32 px/word), 1=2bpp (16), 2=4bpp (8), 3=8bpp (4)
//  flush       in   1   discard held word, return to EMPTY (line end / mode change)
//  wd_valid    in   1   word available from FIFO
//  wd_data     in   32  packed pixel word
//  wd_ready    out  1   word accepted this cycle when wd_valid && wd_ready
//  pix_valid   out  1   pix_data valid
//  pix_ready   in   1   downstream accepts pixel when pix_valid && pix_ready
//  pix_data    out  8   palette index, zero-extended from field width
//  pix_last    out  1   pix_data is the final pixel of the held word
//  dbl         in   1   pixel double enable (present only with UNPACK_PIXEL_DOUBLE_EN)
// BEHAVIOUR
//  - Registers: word_q[31:0], mode_q[1:0], idx[4:0], state {EMPTY, ACTIVE}, phase (doubling only).
//  - Reset: state=EMPTY, idx=0, word_q=0, mode_q=0, phase=0; pix_valid=0, pix_last=0, pix_data=0, wd_ready=0.
//  - pix_valid = (state==ACTIVE). pix_data/pix_last combinational from word_q, mode_q, idx: no extra latency.
//  - Field N at bpp B = word_q[N*B +: B]; N = idx masked to field count (mode 3 uses idx[1:0], etc.).
//  - last_idx = 31/15/7/3 for mode_q 0/1/2/3. pix_last = (idx==last_idx) && (phase==1 if doubling else 1).
//  - Pixel consumed when pix_valid && pix_ready: idx increments (wraps to 0 after last_idx).
//  - wd_ready = !reset && !flush && (state==EMPTY || (pix_valid && pix_ready && pix_last)).
//    Zero-bubble: a new word loads in the same cycle the last pixel of the previous word is consumed.
//  - Word load: word_q<=wd_data, mode_q<=mode, idx<=0, phase<=0, state<=ACTIVE.
//  - Last pixel consumed with no word loaded: state<=EMPTY, idx<=0.
//  - mode is sampled only at word load; changes mid-word take effect on the next word.
//  - pix_ready low: pix_data, pix_last, idx held stable; wd_ready stays low while ACTIVE.
//  - flush: next cycle state=EMPTY, idx=0, phase=0; flush overrides simultaneous wd_valid and pix consume
//    (no word accepted, pixel considered not consumed by this block).
//  - Reset mid-word: held word discarded, no pixel emitted in the cycle after reset.
// CONFIGURATION
//  UNPACK_PIXEL_DOUBLE_EN defined: dbl port exists; if dbl sampled 1 at word load (stored with mode_q), each pixel
//   is presented twice (phase 0 then 1); idx advances only on phase-1 consume; 2x pixels per word.
//  Undefined: no dbl port, no phase register; each pixel presented once.
// TESTING
//  2bpp: load 0xE4E4E4E4, pix_ready=1 -> 16 pixels 0,1,2,3 repeating, pix_last on 16th only, wd_ready on 16th.
//  8bpp back-to-back: words 0x44332211, 0x88776655 with wd_valid/pix_ready high -> 11..88 on 8 consecutive cycles.
//  1bpp: 0x80000001 -> pixel0=1, pixels1..30=0, pixel31=1 with pix_last.
//  Backpressure: 4bpp 0x76543210, drop pix_ready for 3 cycles at idx 2 -> pix_data holds 2, sequence 0..7 intact.
//  Flush at idx 5 of 2bpp word with wd_valid=1 -> no word taken that cycle; next cycle pix_valid=0, then reload.
//  Doubling (macro+dbl=1): 8bpp 0x44332211 -> 11,11,22,22,33,33,44,44; pix_last only on second 44.

Source files
------------

// File: rtl/pixel_unpack_ctrl_if.sv
// Word-in / pixel-out handshake bundle for pixel_unpack_ctrl.
// The dbl signal exists only when UNPACK_PIXEL_DOUBLE_EN is defined.
interface pixel_unpack_ctrl_if;
    logic [1:0]  mode;
    logic        flush;
    logic        wd_valid;
    logic [31:0] wd_data;
    logic        wd_ready;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;
`ifdef UNPACK_PIXEL_DOUBLE_EN
    logic        dbl;

    modport master (
        output mode, flush, wd_valid, wd_data, pix_ready, dbl,
        input  wd_ready, pix_valid, pix_data, pix_last
    );
    modport slave (
        input  mode, flush, wd_valid, wd_data, pix_ready, dbl,
        output wd_ready, pix_valid, pix_data, pix_last
    );
`else
    modport master (
        output mode, flush, wd_valid, wd_data, pix_ready,
        input  wd_ready, pix_valid, pix_data, pix_last
    );
    modport slave (
        input  mode, flush, wd_valid, wd_data, pix_ready,
        output wd_ready, pix_valid, pix_data, pix_last
    );
`endif
endinterface

// File: rtl/pixel_unpack_ctrl.sv
// Unpacks 32-bit FIFO words into 1/2/4/8 bpp palette indices, LS field first.
// Optional pixel doubling is built in when UNPACK_PIXEL_DOUBLE_EN is defined.
module pixel_unpack_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    pixel_unpack_ctrl_if.slave   bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned PIX_W  = 8;

    typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
`ifdef UNPACK_PIXEL_DOUBLE_EN
    logic                dbl_q, dbl_d;
    logic                phase_q, phase_d;
`endif

    logic [IDX_W-1:0]    last_idx;
    logic                phase_done;
    logic                at_last;
    logic                consume;
    logic                take_word;
    logic                load;
    logic [1:0]          fld2;

    // 2bpp field select
    demux_32_2 u_demux (
        .word (word_q),
        .sel  (idx_q[3:0]),
        .fld  (fld2)
    );

    // Shared decode used by both the next-state and output logic
    always_comb begin
        case (mode_q)
            2'd0:    last_idx = IDX_W'(31);
            2'd1:    last_idx = IDX_W'(15);
            2'd2:    last_idx = IDX_W'(7);
            default: last_idx = IDX_W'(3);
        endcase
`ifdef UNPACK_PIXEL_DOUBLE_EN
        phase_done = !dbl_q || phase_q;
`else
        phase_done = 1'b1;
`endif
        at_last   = (idx_q == last_idx) && phase_done;
        consume   = (state_q == ACTIVE) && bus.pix_ready && !bus.flush;
        take_word = !bus.flush && ((state_q == EMPTY) || (consume && at_last));
        load      = bus.wd_valid && take_word;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            word_q  <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
`ifdef UNPACK_PIXEL_DOUBLE_EN
            dbl_q   <= 1'b0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
`ifdef UNPACK_PIXEL_DOUBLE_EN
            dbl_q   <= dbl_d;
            phase_q <= phase_d;
`endif
        end
    end

    // Next state: flush beats load, load beats plain consume
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
`ifdef UNPACK_PIXEL_DOUBLE_EN
        dbl_d   = dbl_q;
        phase_d = phase_q;
`endif
        if (bus.flush) begin
            state_d = EMPTY;
            idx_d   = '0;
`ifdef UNPACK_PIXEL_DOUBLE_EN
            phase_d = 1'b0;
`endif
        end else if (load) begin
            state_d = ACTIVE;
            word_d  = bus.wd_data;
            mode_d  = bus.mode;
            idx_d   = '0;
`ifdef UNPACK_PIXEL_DOUBLE_EN
            dbl_d   = bus.dbl;
            phase_d = 1'b0;
`endif
        end else if (consume) begin
            if (phase_done) begin
                if (idx_q == last_idx) begin
                    state_d = EMPTY;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
`ifdef UNPACK_PIXEL_DOUBLE_EN
            phase_d = !phase_done;
`endif
        end
    end

    // Outputs: pixel fields are decoded directly from the held word
    always_comb begin
        bus.pix_valid = (state_q == ACTIVE);
        bus.pix_last  = at_last;
        bus.wd_ready  = !reset && take_word;
        case (mode_q)
            2'd0:    bus.pix_data = PIX_W'(word_q[idx_q]);
            2'd1:    bus.pix_data = PIX_W'(fld2);
            2'd2:    bus.pix_data = PIX_W'(word_q[{idx_q[2:0], 2'b00} +: 4]);
            default: bus.pix_data = word_q[{idx_q[1:0], 3'b000} +: 8];
        endcase
    end
endmodule

// Selects one of sixteen 2-bit fields, field 0 in bits [1:0].
module demux_32_2 (
    input  logic [31:0] word,
    input  logic [3:0]  sel,
    output logic [1:0]  fld
);
    assign fld = word[{sel, 1'b0} +: 2];
endmodule

// File: tb/tb_pixel_unpack_ctrl.sv
// Bench for pixel_unpack_ctrl: vector table, directed corner sequences and a
// randomized run against a pixel-queue reference model.
module tb_pixel_unpack_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pixel_unpack_ctrl_if u_if ();

    pixel_unpack_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        wv;
        logic [31:0] wd;
        logic        pr;
        logic        wr;
        logic        v;
        logic [7:0]  d;
        logic        l;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; drives inputs, checks at the falling edge.
    task automatic cyc(input logic [1:0] m, input logic wv, input logic [31:0] wd,
                       input logic pr, input logic fl, input logic dbl_i,
                       input logic e_wr, input logic e_v, input logic [7:0] e_d,
                       input logic e_l, input string nm);
        u_if.mode      = m;
        u_if.wd_valid  = wv;
        u_if.wd_data   = wd;
        u_if.pix_ready = pr;
        u_if.flush     = fl;
`ifdef UNPACK_PIXEL_DOUBLE_EN
        u_if.dbl       = dbl_i;
`else
        if (dbl_i) $display("note: dbl ignored in this build");
`endif
        @(negedge clk);
        chk({nm, "/wd_ready"}, 32'(u_if.wd_ready), 32'(e_wr));
        chk({nm, "/pix_valid"}, 32'(u_if.pix_valid), 32'(e_v));
        if (e_v) begin
            chk({nm, "/pix_data"}, 32'(u_if.pix_data), 32'(e_d));
            chk({nm, "/pix_last"}, 32'(u_if.pix_last), 32'(e_l));
        end
        @(posedge clk);
        #1;
    endtask

    // Reference: expand a word into its pixel sequence with plain arithmetic
    task automatic build(input logic [1:0] m, input logic [31:0] w, input logic d);
        int b;
        int cnt;
        b   = 1 << m;
        cnt = 32 / b;
        for (int n = 0; n < cnt; n++) begin
            logic [7:0] v;
            v = 8'((w >> (n * b)) & ((32'd1 << b) - 32'd1));
            mq.push_back(v);
            if (d) mq.push_back(v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        u_if.mode = 2'd0; u_if.wd_valid = 1'b0; u_if.wd_data = '0;
        u_if.pix_ready = 1'b0; u_if.flush = 1'b0;
`ifdef UNPACK_PIXEL_DOUBLE_EN
        u_if.dbl = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset/wd_ready", 32'(u_if.wd_ready), 32'd0);
        chk("reset/pix_valid", 32'(u_if.pix_valid), 32'd0);
        chk("reset/pix_data", 32'(u_if.pix_data), 32'd0);
        chk("reset/pix_last", 32'(u_if.pix_last), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 8bpp back-to-back words
        tbl[0] = '{2'd3, 1'b1, 32'h44332211, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{2'd3, 1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[2] = '{2'd3, 1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
        tbl[3] = '{2'd3, 1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[4] = '{2'd3, 1'b1, 32'h88776655, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1};
        tbl[5] = '{2'd3, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
        tbl[6] = '{2'd3, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
        tbl[7] = '{2'd3, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
        tbl[8] = '{2'd3, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h88, 1'b1};
        tbl[9] = '{2'd3, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 10; i++)
            cyc(tbl[i].mode, tbl[i].wv, tbl[i].wd, tbl[i].pr, 1'b0, 1'b0,
                tbl[i].wr, tbl[i].v, tbl[i].d, tbl[i].l, $sformatf("b2b[%0d]", i));

        // 2bpp repeating 0,1,2,3
        cyc(2'd1, 1'b1, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "bpp2_load");
        for (int i = 0; i < 16; i++)
            cyc(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, i == 15, 1'b1, 8'(i % 4), i == 15,
                $sformatf("bpp2[%0d]", i));
        cyc(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "bpp2_idle");

        // 1bpp end bits
        cyc(2'd0, 1'b1, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "bpp1_load");
        for (int i = 0; i < 32; i++)
            cyc(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, i == 31, 1'b1,
                8'((i == 0) || (i == 31)), i == 31, $sformatf("bpp1[%0d]", i));

        // 4bpp with backpressure at idx 2
        cyc(2'd2, 1'b1, 32'h76543210, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "bp_load");
        for (int i = 0; i < 2; i++)
            cyc(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0, $sformatf("bp[%0d]", i));
        for (int i = 0; i < 3; i++)
            cyc(2'd2, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0,
                $sformatf("bp_hold[%0d]", i));
        for (int i = 2; i < 8; i++)
            cyc(2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, i == 7, 1'b1, 8'(i), i == 7,
                $sformatf("bp[%0d]", i));

        // Flush at idx 5 with a word waiting
        cyc(2'd1, 1'b1, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "fl_load");
        for (int i = 0; i < 5; i++)
            cyc(2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i % 4), 1'b0,
                $sformatf("fl[%0d]", i));
        cyc(2'd3, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, "fl_flush");
        cyc(2'd3, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "fl_reload");
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, "fl_aa");
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, "fl_bb");
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hCC, 1'b0, "fl_cc");
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hDD, 1'b1, "fl_dd");
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "fl_idle");

`ifdef UNPACK_PIXEL_DOUBLE_EN
        // Doubled 8bpp word
        cyc(2'd3, 1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 1'b0, "dbl_load");
        for (int i = 0; i < 8; i++)
            cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, i == 7, 1'b1, 8'(8'h11 * (i / 2 + 1)), i == 7,
                $sformatf("dbl[%0d]", i));
        cyc(2'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, "dbl_idle");
`endif

        // Randomized traffic against the pixel-queue model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  m;
            logic        wv, pr, fl, d, ev, el, ewr;
            logic [7:0]  ed;
            logic [31:0] wd;
            m  = 2'($urandom);
            wd = $urandom;
            wv = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 49) == 0);
`ifdef UNPACK_PIXEL_DOUBLE_EN
            d  = 1'($urandom);
`else
            d  = 1'b0;
`endif
            if (i == 1500) reset = 1'b1;
            ev  = (mq.size() > 0);
            ed  = ev ? mq[0] : 8'h0;
            el  = (mq.size() == 1);
            ewr = !reset && !fl && ((mq.size() == 0) || (pr && mq.size() == 1));
            cyc(m, wv, wd, pr, fl, d, ewr, ev, ed, el, $sformatf("rnd[%0d]", i));
            if (reset) begin
                mq.delete();
                reset = 1'b0;
            end else if (fl) begin
                mq.delete();
            end else begin
                if (pr && ev) void'(mq.pop_front());
                if (wv && ewr) build(m, wd, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
